// File: rtl/chad_intc.sv
// Interrupt controller: 15 synchronized edge-triggered sources with pend/enable
// masks, fixed priority (lowest index wins) and a registered irq/ivec pair.

module chad_intc_src (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic set_sw,
  input  logic clr,
  output logic pend,
  output logic pend_nxt
);
  logic s1, s2, s3;

  // Any set (edge or software) beats a clear arriving on the same edge.
  assign pend_nxt = (s2 & ~s3) | set_sw | (pend & ~clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      pend <= 1'b0;
    end else begin
      s1   <= src;
      s2   <= s1;
      s3   <= s2;
      pend <= pend_nxt;
    end
  end
endmodule

module chad_intc #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             sel,
  input  logic [1:0]       addr,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rdata,
  input  logic [15:0]      src,
  output logic             irq,
  output logic [3:0]       ivec,
  input  logic             iack
);
  localparam logic [1:0] A_PEND  = 2'd0;
  localparam logic [1:0] A_EN    = 2'd1;
  localparam logic [1:0] A_SWSET = 2'd2;
  localparam logic [1:0] A_CTRL  = 2'd3;

  logic        we, ack;
  logic [15:1] pend, pend_nxt, en, en_nxt, set_sw, clr, active_nxt;
  logic        gie, gie_nxt, irq_nxt;
  logic [3:0]  ivec_nxt;

  // Reads are side-effect free; src[0] has no lane.
  logic unused_bits;
  assign unused_bits = ^{io_rd, src[0], din};

  assign we  = sel & io_wr & ~hold;
  assign ack = iack & irq;

  for (genvar k = 1; k < 16; k++) begin : g_src
    chad_intc_src u_src (
      .clk     (clk),
      .reset   (reset),
      .src     (src[k]),
      .set_sw  (set_sw[k]),
      .clr     (clr[k]),
      .pend    (pend[k]),
      .pend_nxt(pend_nxt[k])
    );
  end

  always_comb begin
    set_sw  = '0;
    clr     = '0;
    en_nxt  = en;
    gie_nxt = gie & ~ack;
    for (int k = 1; k < 16; k++)
      if (ack && ivec == 4'(k)) clr[k] = 1'b1;
    if (we) begin
      case (addr)
        A_PEND:  clr     = clr | din[15:1];
        A_EN:    en_nxt  = din[15:1];
        A_SWSET: set_sw  = din[15:1];
        A_CTRL:  gie_nxt = din[0];
        default: ;
      endcase
    end
  end

  // irq/ivec track next-state so they move on the same edge as their cause.
  assign active_nxt = pend_nxt & en_nxt;
  assign irq_nxt    = gie_nxt & (|active_nxt);

  always_comb begin
    ivec_nxt = '0;
    for (int k = 15; k >= 1; k--)
      if (active_nxt[k]) ivec_nxt = 4'(k);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en   <= '0;
      gie  <= 1'b0;
      irq  <= 1'b0;
      ivec <= '0;
    end else begin
      en   <= en_nxt;
      gie  <= gie_nxt;
      irq  <= irq_nxt;
      ivec <= ivec_nxt;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      A_PEND: rdata[15:1] = pend;
      A_EN:   rdata[15:1] = en;
      A_CTRL: begin
        rdata[0]   = gie;
        rdata[1]   = irq;
        rdata[7:4] = ivec;
      end
      default: ;
    endcase
  end
endmodule
